seq_detector_param: RTL

Parametrised Moore-style serial pattern detector, the next generation of the fixed 1010 detector. It watches a 1-bit serial stream qualified by `in_valid` and matches it against a PAT_W-bit pattern, which can be reloaded at runtime. Overlapping or non-overlapping detection is selected by parameter. It raises a one-cycle registered `y` per match and keeps a saturating match counter for the surrounding datapath and testbenches.

---
 rtl/seq_detector_param.sv | 108 ++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial pattern detector.
// Matches a PAT_W-bit pattern (MSB received first) against a qualified
// serial stream, with runtime pattern reload, overlapping or restarting
// detection, a one-cycle registered match pulse and a saturating match counter.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             digit,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_HIT = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_FILL,
        ST_HUNT,
        ST_MATCH
    } state_t;

    state_t           st;
    state_t           st_next;
    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;
    logic [FILL_W-1:0] fill_inc;
    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] pat_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [PAT_W-1:0] shifted;
    logic             accept;
    logic             hit;

    // A pattern load in the same cycle swallows the incoming bit.
    assign accept   = in_valid & ~pat_load;
    assign shifted  = {hist[PAT_W-2:0], digit};
    assign fill_inc = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);
    assign hit      = accept && (fill >= FILL_HIT) && (shifted == pat);

    // Next-state logic for the FSM, history window, fill level, pattern and counter.
    always_comb begin
        st_next    = st;
        hist_next  = hist;
        fill_next  = fill;
        pat_next   = pat;
        count_next = count;

        if (pat_load) begin
            pat_next  = pat_in;
            fill_next = '0;
            st_next   = ST_FILL;
        end else if (accept) begin
            hist_next = shifted;
            if (hit) begin
                st_next   = ST_MATCH;
                fill_next = OVERLAP ? fill_inc : '0;
            end else begin
                fill_next = fill_inc;
                st_next   = (fill_inc == FILL_MAX) ? ST_HUNT : ST_FILL;
            end
        end else if (st == ST_MATCH) begin
            st_next = OVERLAP ? ST_HUNT : ST_FILL;
        end

        if (cnt_clr) begin
            count_next = hit ? CNT_W'(1) : '0;
        end else if (hit && (count != CNT_MAX)) begin
            count_next = count + CNT_W'(1);
        end
    end

    // State register; synchronous reset overrides load, clear and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= ST_FILL;
            hist  <= '0;
            fill  <= '0;
            pat   <= PATTERN;
            count <= '0;
        end else begin
            st    <= st_next;
            hist  <= hist_next;
            fill  <= fill_next;
            pat   <= pat_next;
            count <= count_next;
        end
    end

    assign y           = (st == ST_MATCH);
    assign match_count = count;
    assign cnt_sat     = (count == CNT_MAX);

endmodule
